// File: rtl/inv_sub_bytes.sv
// Iterative AES InvSubBytes: one 128-bit state is substituted LANES bytes per clock,
// with a valid/ready handshake on both sides and exactly one block in flight.
module inv_sub_bytes #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NGRP = 16 / LANES;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);

    // FIPS-197 inverse S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic [127:0]    work_q, work_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // State, group counter, working register and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grp_q       <= {GW{1'b0}};
            work_q      <= 128'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            work_q      <= work_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; only the bytes of the current group are rewritten in SUB.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        work_d  = work_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    grp_d   = {GW{1'b0}};
                    state_d = SUB;
                end else begin
                    state_d = IDLE;
                end
            end
            SUB: begin
                for (int b = 0; b < 16; b++) begin
                    if ((b / LANES) == int'(grp_q)) begin
                        work_d[127-8*b -: 8] = inv_sbox(work_q[127-8*b -: 8]);
                    end else begin
                        work_d[127-8*b -: 8] = work_q[127-8*b -: 8];
                    end
                end
                if (grp_q == LAST_GRP) begin
                    state_d = DONE;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                grp_d   = {GW{1'b0}};
            end
        endcase
    end

    // Status flags are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == SUB) || (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = work_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Bench for inv_sub_bytes: table vectors, stall/reset sequences and a random
// back-to-back run, checked against an inverse S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes;

    localparam int LANES = 4;
    localparam int NGRP  = 16 / LANES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;
    logic         in_valid_1, in_ready_1, out_valid_1, out_ready_1, busy_1;
    logic [127:0] in_state_1, out_state_1;

    always #5 clk = ~clk;

    inv_sub_bytes #(.LANES(LANES)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .busy(busy)
    );

    inv_sub_bytes #(.LANES(1)) u_dut_1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .in_state(in_state_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1), .out_state(out_state_1),
        .busy(busy_1)
    );

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t           vecs [5];
    logic [7:0]     model_inv [256];
    logic [127:0]   exp_q [$];
    int             n_vec = 0;
    int             n_err = 0;
    int             cyc = 0;
    int             n_acc = 0;
    int             n_out = 0;
    int             last_out = -1;
    bit             b2b = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Forward S-box from field inverse plus affine map, then inverted into model_inv.
    task automatic build_model();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            model_inv[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_sub(input logic [127:0] st);
        logic [127:0] r;
        r = 128'h0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = model_inv[st[127-8*i -: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Called at a negedge with inputs already set: scoreboard both handshakes, advance one cycle.
    task automatic tick();
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model_sub(in_state));
            n_acc++;
        end
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb_empty: got out_state %h, want no output", out_state);
            end else begin
                chk("sb_data", out_state, exp_q.pop_front());
            end
            n_out++;
            if (b2b && last_out >= 0) chk("b2b_period", 128'(cyc - last_out), 128'(NGRP + 2));
            last_out = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_vec(input logic [127:0] din, input logic [127:0] exp, input int stall);
        int t, lat;
        in_valid = 1'b1; in_state = din; out_ready = 1'b0; t = 0;
        while (!in_ready && t < 50) begin tick(); t++; end
        tick();
        chk("busy_sub", 128'(busy), 128'(1'b1));
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            lat++;
        end
        chk("latency", 128'(lat), 128'(NGRP));
        chk("result", out_state, exp);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            chk("stall_valid", 128'(out_valid), 128'(1'b1));
            chk("stall_data", out_state, exp);
            chk("stall_in_ready", 128'(in_ready), 128'(1'b0));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("in_ready_after", 128'(in_ready), 128'(1'b1));
        chk("out_valid_after", 128'(out_valid), 128'(1'b0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, guard;
        logic [127:0] d;
        vecs[0] = '{din: {16{8'h63}}, exp: 128'h0};
        vecs[1] = '{din: 128'h637c777bf26b6fc53001672bfed7ab76, exp: 128'h000102030405060708090a0b0c0d0e0f};
        vecs[2] = '{din: 128'h0, exp: {16{8'h52}}};
        vecs[3] = '{din: {16{8'hff}}, exp: {16{8'h7d}}};
        vecs[4] = '{din: 128'h00011663636363636363636363636363, exp: 128'h5209ff00000000000000000000000000};

        rst_n = 1'b1; in_valid = 1'b0; in_state = 128'h0; out_ready = 1'b0;
        in_valid_1 = 1'b0; in_state_1 = 128'h0; out_ready_1 = 1'b0;
        build_model();
        #2 rst_n = 1'b0;
        in_valid = 1'b1; in_state = {16{8'h11}};
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_out_state", out_state, 128'h0);
        chk("rst1_in_ready", 128'(in_ready_1), 128'(1'b1));
        chk("rst1_out_state", out_state_1, 128'h0);
        tick(); tick();
        chk("rst_ignore_valid", 128'(busy), 128'(1'b0));
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i].din, vecs[i].exp, 0);

        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_vec(d, model_sub(d), 10);

        // Reset while the block sits at group 2.
        in_valid = 1'b1; in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("pre_rst_busy", 128'(busy), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("mid_rst_busy", 128'(busy), 128'(1'b0));
        chk("mid_rst_state", out_state, 128'h0);
        exp_q.delete();
        in_valid = 1'b1;
        tick();
        chk("rst_hold_out_valid", 128'(out_valid), 128'(1'b0));
        rst_n = 1'b1;
        chk("accept_after_rst", 128'(in_ready), 128'(1'b1));
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_vec(d, model_sub(d), 0);

        // LANES=1 instance: 16 edges to result.
        chk("l1_in_ready", 128'(in_ready_1), 128'(1'b1));
        in_valid_1 = 1'b1; in_state_1 = vecs[4].din;
        tick();
        in_valid_1 = 1'b0; in_state_1 = {16{8'haa}};
        lat = 0;
        while (!out_valid_1 && lat < 40) begin tick(); lat++; end
        chk("l1_latency", 128'(lat), 128'(16));
        chk("l1_result", out_state_1, vecs[4].exp);
        out_ready_1 = 1'b1;
        tick();
        out_ready_1 = 1'b0;
        chk("l1_in_ready_after", 128'(in_ready_1), 128'(1'b1));

        // Back-to-back random blocks.
        b2b = 1'b1; last_out = -1; n_out = 0; n_acc = 0; guard = 0;
        out_ready = 1'b1;
        while (n_out < 1000 && guard < 1000 * (NGRP + 2) + 200) begin
            in_valid = (n_acc < 1000);
            in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            guard++;
        end
        b2b = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_count", 128'(n_out), 128'(1000));
        chk("b2b_drained", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes.md
INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

Interface
REQ-001 SHALL have parameter LANES, default 4: bytes substituted per cycle; legal values 1, 2, 4, 8, 16 only.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  in_state holds a block to transform.
REQ-005 SHALL have port in_ready  output  1  block can accept a new state.
REQ-006 SHALL have port in_state  input  128  AES state; byte 0 = in_state[127:120], byte 15 = in_state[7:0].
REQ-007 SHALL have port out_valid  output  1  out_state holds a finished result.
REQ-008 SHALL have port out_ready  input  1  consumer accepts out_state.
REQ-009 SHALL have port out_state  output  128  InvSubBytes(in_state), same byte order as in_state.
REQ-010 SHALL have port busy  output  1  high in SUB or DONE.

Function
REQ-011 SHALL map every byte through the FIPS-197 inverse S-box (Table 6), with the table built into the RTL and no external memory-init file.
REQ-012 SHALL implement FSM states IDLE, SUB and DONE.
REQ-013 SHALL drive in_ready high iff the state is IDLE, and out_valid high iff the state is DONE.
REQ-014 SHALL, in IDLE, capture in_state into the working register and enter SUB on an edge with in_valid && in_ready; the group counter SHALL be cleared to 0.
REQ-015 SHALL, in SUB, replace group k (bytes k*LANES .. k*LANES+LANES-1) of the working register with its inverse S-box values on each edge, then increment k.
REQ-016 SHALL go from SUB to DONE on the edge that writes group N-1 (N = 16/LANES), with no wrap of k.
REQ-017 SHALL raise out_valid exactly N edges after the accept edge (LANES=4: 4 cycles; LANES=16: 1 cycle).
REQ-018 SHALL, in DONE, hold out_state and out_valid stable until out_ready is high; on that edge it SHALL enter IDLE.
REQ-019 SHALL allow in_ready to go high only on the cycle after the output handshake, with no accept in the same cycle as out_valid && out_ready (no overlap, one block in flight).
REQ-020 SHALL leave out_state unchanged by in_state and in_valid while in SUB or DONE; input changes there SHALL be ignored.
REQ-021 SHALL continuously drive out_state from the working register; its value outside DONE is don't-care for checking.
REQ-022 SHALL never touch a byte outside the current group during SUB, and no byte SHALL be substituted twice.

Reset
REQ-023 SHALL, while rst_n is low, force state IDLE, group counter 0, working register 0, out_valid 0, busy 0 and in_ready 1, independent of clk.
REQ-024 SHALL, on reset asserted mid-SUB or mid-DONE, discard the block in flight with no out_valid pulse; after release it SHALL accept a new block on the first edge with in_valid.
REQ-025 SHALL ignore in_valid while rst_n is low.

Verification
REQ-026 Bench SHALL cover: in_state = 16 bytes of 0x63, LANES=4 -> out_valid on the 4th edge after accept, out_state = 0x00000000000000000000000000000000.
REQ-027 Bench SHALL cover: in_state = 637c777bf26b6fc53001672bfed7ab76 -> out_state = 000102030405060708090a0b0c0d0e0f.
REQ-028 Bench SHALL cover: in_state = 00 01 16 ... (byte0=0x00, byte1=0x01, byte2=0x16, rest 0x63), LANES=1 -> byte0=0x52, byte1=0x09, byte2=0xFF, rest 0x00, with out_valid 16 edges after accept.
REQ-029 Bench SHALL cover: out_ready held low 10 cycles in DONE -> out_valid and out_state stable, in_ready low, in_valid pulses ignored; after out_ready rises -> IDLE and in_ready high next cycle.
REQ-030 Bench SHALL cover: rst_n pulsed low at group k=2 -> out_valid never rises for that block, in_ready high immediately; a new block then gives a correct result.
REQ-031 Bench SHALL cover: back-to-back blocks with in_valid and out_ready tied high -> one result per N+2 cycles, all outputs matching a reference model for 1000 random states.
